// File: rtl/eth_tx_nibble_framer_if.sv
// Byte-stream source plus PHY nibble side of the Ethernet TX framer.
// Handshake: a byte moves on a rising edge where o_tx_ready and i_tx_valid are both high;
// o_tx_ready depends only on framer state, never on i_tx_valid.
interface eth_tx_nibble_framer_if;
    logic [7:0]  i_tx_data;
    logic        i_tx_valid;
    logic        i_tx_last;
    logic        o_tx_ready;
    logic [15:0] i_tx_gap_count;
    logic [3:0]  o_tx_phy_data;
    logic        o_tx_phy_dv;
    logic        o_tx_fsm_busy;
    logic        o_tx_frame_done;
    logic        o_tx_underrun;

    modport master (
        output i_tx_data, i_tx_valid, i_tx_last, i_tx_gap_count,
        input  o_tx_ready, o_tx_phy_data, o_tx_phy_dv, o_tx_fsm_busy,
               o_tx_frame_done, o_tx_underrun
    );

    modport slave (
        input  i_tx_data, i_tx_valid, i_tx_last, i_tx_gap_count,
        output o_tx_ready, o_tx_phy_data, o_tx_phy_dv, o_tx_fsm_busy,
               o_tx_frame_done, o_tx_underrun
    );
endinterface

// File: rtl/eth_tx_nibble_framer.sv
// Ethernet TX framer: wraps a byte stream in preamble/SFD, pads to a minimum length,
// appends the CRC-32 FCS and emits everything as nibbles, low nibble first.
module eth_tx_nibble_framer #(
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic                          i_main_clk,
    input  logic                          i_rst_n,
    eth_tx_nibble_framer_if.slave         bus,
    output logic [2:0]                    o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PREAMBLE = 3'd1,
        S_DATA     = 3'd2,
        S_PAD      = 3'd3,
        S_FCS      = 3'd4,
        S_GAP      = 3'd5
    } state_t;

    localparam logic [16:0] MIN_BYTES = 17'(MIN_FRAME_BYTES);

    state_t      state_q, state_d;
    logic [3:0]  nib_q, nib_d;
    logic [7:0]  byte_q, byte_d;
    logic [15:0] byte_cnt_q, byte_cnt_d;
    logic [16:0] gap_cnt_q, gap_cnt_d;
    logic [15:0] gap_lat_q, gap_lat_d;
    logic [31:0] crc_q, crc_d;
    logic        last_q, last_d;
    logic        underrun_q, underrun_d;

    logic [15:0] byte_inc;
    logic        below_min;
    state_t      gap_state;
    logic [16:0] gap_load;
    logic [31:0] fcs;
    logic [3:0]  phy_data;
    logic        phy_dv;
    logic        ready;
    logic        done;

    // Reflected CRC-32, one nibble at a time, LSB first, so low-then-high nibble
    // order matches the bit order of a byte-wise reflected CRC.
    function automatic logic [31:0] crc32_nibble(input logic [31:0] crc, input logic [3:0] nib);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 4; i++) begin
            if (c[0] ^ nib[i]) c = (c >> 1) ^ 32'hEDB8_8320;
            else               c = c >> 1;
        end
        return c;
    endfunction

    always_ff @(posedge i_main_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= S_IDLE;
            nib_q      <= 4'd0;
            byte_q     <= 8'd0;
            byte_cnt_q <= 16'd0;
            gap_cnt_q  <= 17'd0;
            gap_lat_q  <= 16'd0;
            crc_q      <= 32'hFFFF_FFFF;
            last_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            nib_q      <= nib_d;
            byte_q     <= byte_d;
            byte_cnt_q <= byte_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            gap_lat_q  <= gap_lat_d;
            crc_q      <= crc_d;
            last_q     <= last_d;
            underrun_q <= underrun_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        nib_d      = nib_q;
        byte_d     = byte_q;
        byte_cnt_d = byte_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        gap_lat_d  = gap_lat_q;
        crc_d      = crc_q;
        last_d     = last_q;
        underrun_d = 1'b0;
        phy_data   = 4'd0;
        phy_dv     = 1'b0;
        ready      = 1'b0;
        done       = 1'b0;

        byte_inc  = (byte_cnt_q == 16'hFFFF) ? byte_cnt_q : byte_cnt_q + 16'd1;
        below_min = ({1'b0, byte_inc} < MIN_BYTES);
        // Both the normal end of frame and an underrun leave through the same gap logic.
        gap_state = (gap_lat_q == 16'd0) ? S_IDLE : S_GAP;
        gap_load  = {gap_lat_q, 1'b0} - 17'd1;
        fcs       = ~crc_q;

        case (state_q)
            S_IDLE: begin
                nib_d      = 4'd0;
                byte_cnt_d = 16'd0;
                crc_d      = 32'hFFFF_FFFF;
                last_d     = 1'b0;
                if (bus.i_tx_valid) begin
                    gap_lat_d = bus.i_tx_gap_count;
                    state_d   = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                phy_dv   = 1'b1;
                phy_data = (nib_q == 4'd15) ? 4'hD : 4'h5;
                nib_d    = nib_q + 4'd1;
                if (nib_q == 4'd15) begin
                    ready = 1'b1;
                    nib_d = 4'd0;
                    if (bus.i_tx_valid) begin
                        byte_d  = bus.i_tx_data;
                        last_d  = bus.i_tx_last;
                        state_d = S_DATA;
                    end else begin
                        underrun_d = 1'b1;
                        gap_cnt_d  = gap_load;
                        state_d    = gap_state;
                    end
                end
            end
            S_DATA: begin
                phy_dv   = 1'b1;
                phy_data = nib_q[0] ? byte_q[7:4] : byte_q[3:0];
                crc_d    = crc32_nibble(crc_q, phy_data);
                nib_d    = {3'd0, ~nib_q[0]};
                if (nib_q[0]) begin
                    byte_cnt_d = byte_inc;
                    if (!last_q) begin
                        ready = 1'b1;
                        if (bus.i_tx_valid) begin
                            byte_d = bus.i_tx_data;
                            last_d = bus.i_tx_last;
                        end else begin
                            underrun_d = 1'b1;
                            gap_cnt_d  = gap_load;
                            state_d    = gap_state;
                        end
                    end else begin
                        nib_d   = 4'd0;
                        state_d = below_min ? S_PAD : S_FCS;
                    end
                end
            end
            S_PAD: begin
                phy_dv = 1'b1;
                crc_d  = crc32_nibble(crc_q, 4'd0);
                nib_d  = {3'd0, ~nib_q[0]};
                if (nib_q[0]) begin
                    byte_cnt_d = byte_inc;
                    if (!below_min) begin
                        nib_d   = 4'd0;
                        state_d = S_FCS;
                    end
                end
            end
            S_FCS: begin
                phy_dv   = 1'b1;
                phy_data = fcs[{nib_q[2:0], 2'b00} +: 4];
                nib_d    = nib_q + 4'd1;
                if (nib_q == 4'd7) begin
                    done      = 1'b1;
                    nib_d     = 4'd0;
                    gap_cnt_d = gap_load;
                    state_d   = gap_state;
                end
            end
            S_GAP: begin
                gap_cnt_d = gap_cnt_q - 17'd1;
                if (gap_cnt_q == 17'd0) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.o_tx_phy_data   = phy_data;
    assign bus.o_tx_phy_dv     = phy_dv;
    assign bus.o_tx_ready      = ready;
    assign bus.o_tx_fsm_busy   = (state_q != S_IDLE);
    assign bus.o_tx_frame_done = done;
    assign bus.o_tx_underrun   = underrun_q;
    assign o_dbg_state         = state_q;

endmodule
